pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter_if.sv | 28 ++
 rtl/pipe_arbiter.sv | 129 ++++++++++++
 tb/tb_pipe_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the external
// fixed-latency pipe.
interface pipe_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    en_mask;
  logic [NREQ-1:0]    gnt;
  logic               pipe_vld;
  logic [DW-1:0]      pipe_data_in;
  logic [DW-1:0]      pipe_data_out;
  logic [NREQ-1:0]    rsp_vld;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  modport slave (
    input  req, req_lock, req_data, en_mask, pipe_data_out,
    output gnt, pipe_vld, pipe_data_in, rsp_vld, rsp_data, busy
  );

  modport master (
    output req, req_lock, req_data, en_mask, pipe_data_out,
    input  gnt, pipe_vld, pipe_data_in, rsp_vld, rsp_data, busy
  );
endinterface

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter with bounded burst locking that feeds one beat per cycle
// into a fixed-latency pipe and routes the returning beats by a tag chain.
module pipe_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int LAT       = 3,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipe_arbiter_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_last_gnt;
  logic [CW-1:0]  r_burst_cnt;
  logic [LAT-1:0] r_tag_vld;
  logic [IDW-1:0] r_tag_id [LAT];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_cand;
  logic            w_owner_hold;
  logic            w_at_max;
  logic            w_others;
  logic [IDW:0]    w_pick;
  logic            w_grant;
  logic [IDW-1:0]  w_win_idx;
  logic [1:0]      w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // Returns {found, index} of the first candidate after 'last', wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] cand,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!res[IDW] && cand[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  assign w_elig       = bus.req & bus.en_mask;
  assign w_owner_oh   = NREQ'(1) << r_last_gnt;
  assign w_owner_hold = (r_state == ST_LOCKED) && w_elig[r_last_gnt] &&
                        bus.req_lock[r_last_gnt];
  assign w_at_max     = (r_burst_cnt == CW'(MAX_BURST));
  assign w_others     = |(w_elig & ~w_owner_oh);
  // An owner at its burst limit steps aside for one search only.
  assign w_cand       = (w_owner_hold && w_at_max) ? (w_elig & ~w_owner_oh) : w_elig;
  assign w_pick       = rr_pick(w_cand, r_last_gnt);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
    w_grant     = 1'b0;
    w_win_idx   = r_last_gnt;
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = '0;
    if (!rst) begin
      if (w_owner_hold && (!w_at_max || !w_others)) begin
        w_grant     = 1'b1;
        w_win_idx   = r_last_gnt;
        w_state_nxt = ST_LOCKED;
        w_cnt_nxt   = w_at_max ? CW'(1) : r_burst_cnt + CW'(1);
      end else if (w_pick[IDW]) begin
        w_grant   = 1'b1;
        w_win_idx = w_pick[IDW-1:0];
        if (bus.req_lock[w_win_idx]) begin
          w_state_nxt = ST_LOCKED;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = '0;
        end
      end
    end
  end

  always_comb begin
    bus.gnt          = '0;
    bus.pipe_data_in = '0;
    if (w_grant) begin
      bus.gnt[w_win_idx] = 1'b1;
      bus.pipe_data_in   = bus.req_data[w_win_idx*DW +: DW];
    end
  end

  assign bus.pipe_vld = w_grant;

  always_comb begin
    bus.rsp_vld  = '0;
    bus.rsp_data = '0;
    if (r_tag_vld[LAT-1]) begin
      bus.rsp_vld[r_tag_id[LAT-1]] = 1'b1;
      bus.rsp_data                 = bus.pipe_data_out;
    end
  end

  assign bus.busy = |r_tag_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= IDW'(NREQ - 1);
      r_burst_cnt <= '0;
      r_tag_vld   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
      if (w_grant) r_last_gnt <= w_win_idx;
      r_tag_vld[0] <= w_grant;
      for (int i = 1; i < LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
  end

  // NOTE: tag ids are not reset; they are only observed when the matching valid bit is set.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_win_idx;
    for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
  end
endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter; the external pipe is modelled as a LAT-deep
// shift register of pipe_data_in.
module tb_pipe_arbiter;
  localparam int NREQ = 4, DW = 4, LAT = 3, MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  pipe_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= bus.pipe_data_in;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign bus.pipe_data_out = pipe_q[LAT-1];

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [3:0] en, input logic [15:0] d);
    @(negedge clk);
    rst = r; bus.req = rq; bus.req_lock = lk; bus.en_mask = en; bus.req_data = d;
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b1, 4'h0, 4'h0, 4'hF, 16'h0);
    drive(1'b1, 4'h0, 4'h0, 4'hF, 16'h0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'hF, 4'hF, 4'hF, 16'h1234);
      total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL rst_gnt cyc=%0d got=%b exp=0000", c, bus.gnt); end
      total++; if (bus.pipe_vld !== 1'b0) begin bad++; $display("FAIL rst_pipe_vld cyc=%0d got=%b exp=0", c, bus.pipe_vld); end
      total++; if (bus.pipe_data_in !== 4'h0) begin bad++; $display("FAIL rst_pipe_data cyc=%0d got=%h exp=0", c, bus.pipe_data_in); end
    end
    drive(1'b0, 4'h0, 4'h0, 4'hF, 16'h0);
    total++; if (bus.rsp_vld !== 4'h0) begin bad++; $display("FAIL rst_rsp_vld got=%b exp=0000", bus.rsp_vld); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rsp_data !== 4'h0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", bus.rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] er [9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};
    logic [3:0] ed [9] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'h0};
    logic       eb [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, (c < 5) ? 4'hF : 4'h0, 4'h0, 4'hF, 16'hDCBA);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
      total++; if (bus.rsp_vld !== er[c]) begin bad++; $display("FAIL rr_rsp_vld cyc=%0d got=%b exp=%b", c, bus.rsp_vld, er[c]); end
      total++; if (bus.rsp_data !== ed[c]) begin bad++; $display("FAIL rr_rsp_data cyc=%0d got=%h exp=%h", c, bus.rsp_data, ed[c]); end
      total++; if (bus.busy !== eb[c]) begin bad++; $display("FAIL rr_busy cyc=%0d got=%b exp=%b", c, bus.busy, eb[c]); end
    end
  endtask

  task automatic test_lock_burst();
    logic [3:0] eg [6] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h4};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, (c == 0) ? 4'h4 : 4'h5, 4'h4, 4'hF, 16'h0);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
    end
  endtask

  task automatic test_lock_wrap();
    logic [3:0] eg [9] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, (c < 6) ? 4'h2 : 4'h3, 4'h2, 4'hF, 16'h0);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL wrap_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
    end
  endtask

  task automatic test_echo();
    logic [3:0] eg [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ep [5] = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] er [5] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    logic [3:0] ed [5] = '{4'h0, 4'h0, 4'h0, 4'h5, 4'h0};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, (c == 0) ? 4'h1 : 4'h0, 4'h0, 4'hF, 16'h9875);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL echo_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
      total++; if (bus.pipe_vld !== (eg[c] != 4'h0)) begin bad++; $display("FAIL echo_pipe_vld cyc=%0d got=%b", c, bus.pipe_vld); end
      total++; if (bus.pipe_data_in !== ep[c]) begin bad++; $display("FAIL echo_pipe_data cyc=%0d got=%h exp=%h", c, bus.pipe_data_in, ep[c]); end
      total++; if (bus.rsp_vld !== er[c]) begin bad++; $display("FAIL echo_rsp_vld cyc=%0d got=%b exp=%b", c, bus.rsp_vld, er[c]); end
      total++; if (bus.rsp_data !== ed[c]) begin bad++; $display("FAIL echo_rsp_data cyc=%0d got=%h exp=%h", c, bus.rsp_data, ed[c]); end
      total++; if (bus.busy !== eb[c]) begin bad++; $display("FAIL echo_busy cyc=%0d got=%b exp=%b", c, bus.busy, eb[c]); end
    end
  endtask

  task automatic test_reset_flush();
    logic       rs [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] rq [9] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [3:0] eg [9] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [3:0] er [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [3:0] ed [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      drive(rs[c], rq[c], 4'h0, 4'hF, 16'h4321);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL flush_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
      if (c >= 3) begin
        total++; if (bus.rsp_vld !== er[c]) begin bad++; $display("FAIL flush_rsp_vld cyc=%0d got=%b exp=%b", c, bus.rsp_vld, er[c]); end
        total++; if (bus.rsp_data !== ed[c]) begin bad++; $display("FAIL flush_rsp_data cyc=%0d got=%h exp=%h", c, bus.rsp_data, ed[c]); end
      end
      if (c == 3 || c == 4) begin
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy cyc=%0d got=%b exp=0", c, bus.busy); end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] eg [7] = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 4'hF, 4'h0, 4'hB, 16'h0);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL mask_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
    end
  endtask

  task automatic test_mask_lock();
    logic [3:0] rq [8] = '{4'h2, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] en [8] = '{4'hF, 4'hF, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0] eg [8] = '{4'h2, 4'h2, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] er [8] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h1, 4'h2, 4'h0};
    logic [3:0] ed [8] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 4'h5, 4'hA, 4'h0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, rq[c], 4'h2, en[c], 16'h00A5);
      total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL mlock_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
      total++; if (bus.rsp_vld !== er[c]) begin bad++; $display("FAIL mlock_rsp_vld cyc=%0d got=%b exp=%b", c, bus.rsp_vld, er[c]); end
      total++; if (bus.rsp_data !== ed[c]) begin bad++; $display("FAIL mlock_rsp_data cyc=%0d got=%h exp=%h", c, bus.rsp_data, ed[c]); end
    end
  endtask

  initial begin
    bus.req = '0; bus.req_lock = '0; bus.en_mask = '1; bus.req_data = '0;
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_lock_wrap();
    test_echo();
    test_reset_flush();
    test_mask();
    test_mask_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
